// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps all input vectors into a gate and checks its output against an expected truth table
module truth_table_sequencer #(
  parameter int N_IN = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b1101,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dut_out,
  output logic [N_IN-1:0]       vec,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [(1<<N_IN)-1:0]  mismatch_map,
  output logic [N_IN:0]         err_count
);
  localparam int R = 1 << N_IN;
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [N_IN-1:0] row_q, row_d, vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, mis;
  logic [R-1:0] map_q, map_d;
  logic [N_IN:0] err_q, err_d;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    vec_d = vec_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    map_d = map_q;
    err_d = err_q;
    mis = (dut_out !== EXPECTED[row_q]);
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = DRIVE;
        row_d = '0;
        vec_d = '0;
        cnt_d = '0;
        map_d = '0;
        err_d = '0;
        busy_d = 1'b1;
        done_d = 1'b0;
        pass_d = 1'b0;
      end
      DRIVE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETTLE - 1)) state_d = SAMPLE;
      end
      default: begin
        map_d[row_q] = map_q[row_q] | mis;
        err_d = err_q + {{N_IN{1'b0}}, mis};
        if (row_q == N_IN'(R - 1)) begin
          state_d = DONE;
          vec_d = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_d == '0);
        end else begin
          state_d = DRIVE;
          row_d = row_q + 1'b1;
          vec_d = row_q + 1'b1;
          cnt_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      vec_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      map_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      vec_q <= vec_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      map_q <= map_d;
      err_q <= err_d;
    end
  end
  assign vec = vec_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign mismatch_map = map_q;
  assign err_count = err_q;
endmodule
